// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory host arbiter.
package mem_arb_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  // Width of the per-transaction timeout timer.
  localparam int TIMER_W = 8;

  // Width of a requester id (two requesters).
  localparam int GRANT_W = 1;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin picker: the lone valid requester wins, a tie goes to
// whoever was not granted last.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0]         valid,
  input  logic [GRANT_W-1:0] last_grant,
  output logic               any,
  output logic [GRANT_W-1:0] winner
);

  // Resolve the winner purely from current requests and grant history.
  always_comb begin
    any = |valid;
    if (valid == 2'b11) begin
      winner = ~last_grant;
    end else begin
      winner = valid[1];
    end
  end

endmodule : mem_arb_rr_pick

// File: rtl/mem_host_arbiter.sv
// Round-robin sequencer placing one command at a time on the memory host's
// single-port interface, with a per-transaction timeout.
module mem_host_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  pon_rst_n_i,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_accept,
  output logic                  req0_rsp_valid,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_accept,
  output logic                  req1_rsp_valid,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_ready,
  input  logic                  mem_error,
  output logic                  busy,
  output logic [7:0]            timeout_count
);

  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT - 1);

  arb_state_e             state, next_state;
  logic [GRANT_W-1:0]     last_grant;
  logic [GRANT_W-1:0]     cmd_id;
  logic                   cmd_we;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [DATA_WIDTH-1:0]  cmd_wdata;
  logic [TIMER_W-1:0]     timer;
  logic [1:0]             rsp_valid_q;
  logic [1:0]             rsp_err_q;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q [2];
  logic                   pick_any;
  logic [GRANT_W-1:0]     pick_winner;
  logic                   timed_out;

  mem_arb_rr_pick u_pick (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .any        (pick_any),
    .winner     (pick_winner)
  );

  // Next-state, accept strobes and host enables for the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    next_state   = state;
    req0_accept  = 1'b0;
    req1_accept  = 1'b0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    timed_out    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          next_state  = ISSUE;
          req0_accept = (pick_winner == 1'b0);
          req1_accept = (pick_winner == 1'b1);
        end
      end
      ISSUE: begin
        // Enables fall in the ready cycle so the host never relaunches.
        mem_write_en = cmd_we & ~mem_ready;
        mem_read_en  = ~cmd_we & ~mem_ready;
        if (mem_ready) begin
          next_state = RESP;
        end else if (timer == TIMER_LIMIT) begin
          timed_out  = 1'b1;
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register, command latch, timer and registered responses.
  always_ff @(posedge clk) begin
    if (!pon_rst_n_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state          <= IDLE;
      last_grant     <= 1'b1;
      cmd_id         <= '0;
      cmd_we         <= 1'b0;
      cmd_addr       <= '0;
      cmd_wdata      <= '0;
      timer          <= '0;
      rsp_valid_q    <= '0;
      rsp_err_q      <= '0;
      rsp_rdata_q[0] <= '0;
      rsp_rdata_q[1] <= '0;
      timeout_count  <= '0;
    end else begin
      state       <= next_state;
      rsp_valid_q <= '0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            cmd_id    <= pick_winner;
            cmd_we    <= pick_winner ? req1_we    : req0_we;
            cmd_addr  <= pick_winner ? req1_addr  : req0_addr;
            cmd_wdata <= pick_winner ? req1_wdata : req0_wdata;
            timer     <= '0;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            rsp_valid_q[cmd_id] <= 1'b1;
            rsp_rdata_q[cmd_id] <= (cmd_we | mem_error) ? '0 : mem_data_out;
            rsp_err_q[cmd_id]   <= mem_error;
          end else if (timed_out) begin
            rsp_valid_q[cmd_id] <= 1'b1;
            rsp_rdata_q[cmd_id] <= '0;
            rsp_err_q[cmd_id]   <= 1'b1;
            if (timeout_count != 8'hFF) begin
              timeout_count <= timeout_count + 8'd1;
            end
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        RESP:    last_grant <= cmd_id;
        default: ;
      endcase
    end
  end

  assign busy           = (state != IDLE);
  assign mem_addr       = cmd_addr;
  assign mem_data_in    = cmd_wdata;
  assign req0_rsp_valid = rsp_valid_q[0];
  assign req1_rsp_valid = rsp_valid_q[1];
  assign req0_err       = rsp_err_q[0];
  assign req1_err       = rsp_err_q[1];
  assign req0_rdata     = rsp_rdata_q[0];
  assign req1_rdata     = rsp_rdata_q[1];

endmodule : mem_host_arbiter

// File: tb/tb_mem_host_arbiter.sv
// Self-checking bench: a behavioural host memory answers commands, and a
// transaction-level reference model predicts grant order, data and errors.
module tb_mem_host_arbiter;

  localparam int AW      = 6;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          pon_rst_n_i;
  logic          req0_valid, req0_we, req1_valid, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          req0_accept, req0_rsp_valid, req0_err;
  logic          req1_accept, req1_rsp_valid, req1_err;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic          mem_write_en, mem_read_en;
  logic [DW-1:0] mem_data_out;
  logic          mem_ready, mem_error;
  logic          busy;
  logic [7:0]    timeout_count;

  mem_host_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .pon_rst_n_i(pon_rst_n_i),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_accept(req0_accept), .req0_rsp_valid(req0_rsp_valid), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_accept(req1_accept), .req1_rsp_valid(req1_rsp_valid), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_data_out(mem_data_out), .mem_ready(mem_ready), .mem_error(mem_error),
    .busy(busy), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural host: answers host_lat cycles after first seeing an enable
  // (host_lat < 0 means never), optionally flagging an error.
  logic [DW-1:0] host_mem [64];
  int            host_lat = 3;
  bit            host_err = 1'b0;
  int            h_cnt = 0;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_data;

  initial begin
    mem_ready    = 1'b0;
    mem_error    = 1'b0;
    mem_data_out = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        mem_error = 1'b0;
        h_cnt     = 0;
      end else if (mem_read_en || mem_write_en) begin
        if (h_cnt == 0) begin
          h_we   = mem_write_en;
          h_addr = mem_addr;
          h_data = mem_data_in;
        end
        if (host_lat >= 0 && h_cnt == host_lat) begin
          mem_ready = 1'b1;
          mem_error = host_err;
          if (host_err) begin
            mem_data_out = '0;
          end else if (h_we) begin
            host_mem[h_addr] = h_data;
            mem_data_out     = DW'($urandom);
          end else begin
            mem_data_out = host_mem[h_addr];
          end
          h_cnt = 0;
        end else begin
          h_cnt++;
        end
      end else begin
        h_cnt = 0;
      end
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [64];
  logic          ref_last = 1'b1;
  int            ref_tc   = 0;

  // One transaction: present requests, check the grant, follow the host
  // exchange and check the response against the reference model.
  task automatic run_txn(input logic v0, input logic v1, input logic we0, input logic we1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input int lat, input bit herr, input bit hold);
    logic          win, exp_we, exp_err;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd, exp_rd, obs_rd;
    int            t0, en_cnt, exp_lat, exp_en;
    bit            found;
    host_lat = lat;
    host_err = herr;
    @(negedge clk);
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    #1;
    win = (v0 && v1) ? ~ref_last : v1;
    check("accept", {req1_accept, req0_accept}, win ? 2'b10 : 2'b01);
    check("busy_idle", busy, 1'b0);
    t0       = cyc;
    exp_we   = win ? we1 : we0;
    exp_addr = win ? a1 : a0;
    exp_wd   = win ? d1 : d0;
    exp_err  = herr || (lat < 0);
    exp_rd   = (!exp_we && !exp_err) ? ref_mem[exp_addr] : '0;
    exp_lat  = (lat < 0) ? TIMEOUT + 1 : lat + 2;
    exp_en   = (lat < 0) ? TIMEOUT : lat;
    @(negedge clk);
    if (!hold) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_addr = AW'($urandom); req1_addr = AW'($urandom);
      req0_wdata = DW'($urandom); req1_wdata = DW'($urandom);
      req0_we = ~req0_we; req1_we = ~req1_we;
      #1;
    end
    found  = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (req0_rsp_valid || req1_rsp_valid) begin
        found = 1'b1;
        break;
      end
      if (mem_read_en || mem_write_en) begin
        en_cnt++;
        check("en_kind", {mem_write_en, mem_read_en}, exp_we ? 2'b10 : 2'b01);
        check("mem_addr", mem_addr, exp_addr);
        if (exp_we) check("mem_data_in", mem_data_in, exp_wd);
      end
      check("no_accept_busy", {req1_accept, req0_accept}, 2'b00);
      @(negedge clk);
    end
    check("rsp_seen", found, 1'b1);
    if (found) begin
      obs_rd = win ? req1_rdata : req0_rdata;
      check("rsp_who", {req1_rsp_valid, req0_rsp_valid}, win ? 2'b10 : 2'b01);
      check("rsp_rdata", obs_rd, exp_rd);
      check("rsp_err", win ? req1_err : req0_err, exp_err);
      check("latency", cyc - t0, exp_lat);
      check("en_cycles", en_cnt, exp_en);
      check("resp_en_low", {mem_write_en, mem_read_en}, 2'b00);
      check("resp_no_accept", {req1_accept, req0_accept}, 2'b00);
      if (lat < 0) ref_tc = (ref_tc >= 255) ? 255 : ref_tc + 1;
      check("timeout_count", timeout_count, ref_tc);
    end
    ref_last = win;
    if (exp_we && !exp_err) ref_mem[exp_addr] = exp_wd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      host_mem[i] = DW'($urandom);
      ref_mem[i]  = host_mem[i];
    end
    host_mem[5] = 8'hA5;
    ref_mem[5]  = 8'hA5;
    pon_rst_n_i = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_en", {mem_write_en, mem_read_en}, 2'b00);
    check("rst_rsp_valid", {req1_rsp_valid, req0_rsp_valid}, 2'b00);
    check("rst_rdata", {req1_rdata, req0_rdata}, 16'h0);
    check("rst_err", {req1_err, req0_err}, 2'b00);
    check("rst_tc", timeout_count, 8'd0);
    check("rst_mem_addr", mem_addr, '0);
    pon_rst_n_i = 1'b1;

    // Single read, write, read-back.
    run_txn(1, 0, 0, 0, 6'd5, 6'd0, 8'h00, 8'h00, 3, 0, 0);
    run_txn(0, 1, 0, 1, 6'd0, 6'h3F, 8'h00, 8'h5C, 3, 0, 0);
    run_txn(1, 0, 0, 0, 6'h3F, 6'd0, 8'h00, 8'h00, 3, 0, 0);

    // Contention: both held valid for four transactions.
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, 1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom),
              DW'($urandom), DW'($urandom), $urandom_range(1, 5), 0, 1);

    // Host error, then a normal transaction.
    run_txn(1, 0, 0, 0, 6'd7, 6'd0, 8'h00, 8'h00, 2, 1, 0);
    run_txn(0, 1, 1, 1, 6'd0, 6'd7, 8'h00, 8'h3C, 2, 1, 0);
    run_txn(1, 0, 0, 0, 6'd7, 6'd0, 8'h00, 8'h00, 2, 0, 0);

    // Ready on the last allowed cycle is a success.
    run_txn(1, 0, 0, 0, 6'd9, 6'd0, 8'h00, 8'h00, TIMEOUT - 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      logic v0, v1;
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      run_txn(v0, v1, 1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom),
              DW'($urandom), DW'($urandom), $urandom_range(1, 6),
              ($urandom_range(0, 4) == 0), 1'($urandom));
    end

    // Timeouts, including saturation of the counter.
    for (int i = 0; i < 256; i++)
      run_txn(1'($urandom), 1'b1, 1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom),
              DW'($urandom), DW'($urandom), -1, 0, 0);

    // Reset in the middle of ISSUE.
    host_lat = 10;
    host_err = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd3;
    #1;
    check("mid_accept", req0_accept, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    check("mid_read_en", mem_read_en, 1'b1);
    pon_rst_n_i = 1'b0;
    @(negedge clk);
    check("mid_rst_en", {mem_write_en, mem_read_en}, 2'b00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rsp", {req1_rsp_valid, req0_rsp_valid}, 2'b00);
    pon_rst_n_i = 1'b1;
    ref_last = 1'b1;
    ref_tc   = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_rsp", {req1_rsp_valid, req0_rsp_valid}, 2'b00);
      check("post_rst_tc", timeout_count, 8'd0);
    end
    run_txn(1, 1, 0, 0, 6'd5, 6'd9, 8'h00, 8'h00, 3, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_host_arbiter
